uflash_emu: RTL and testbench

Behavioural, synthesizable responder for the UserFlash request bus (sel / w_strb / addr / data_i / ready / data_o). It mimics the Gowin UserFlash: page erase sets bits to 1, program can only clear bits, and each operation has a flash-like busy time. It lets UserFlash clients run unmodified in simulation, and on parts with no UserFlash, by substituting for the flash controller.

---
 rtl/uflash_emu_if.sv | 19 +
 rtl/uflash_emu.sv | 113 +++++++++++
 tb/tb_uflash_emu.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uflash_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : uflash_emu_if
// Purpose  : UserFlash request bus (sel / w_strb / addr / data_i / ready / data_o / err)
// Revision : 1.0 - initial release
// ============================================================================
interface uflash_emu_if;
   logic        sel;
   logic [3:0]  w_strb;
   logic [14:0] addr;
   logic [31:0] data_i;
   logic        ready;
   logic [31:0] data_o;
   logic        err;

   modport master (output sel, w_strb, addr, data_i, input ready, data_o, err);
   modport slave  (input sel, w_strb, addr, data_i, output ready, data_o, err);
endinterface
`default_nettype wire

// File: rtl/uflash_emu.sv
`default_nettype none
// ============================================================================
// Module   : uflash_emu
// Purpose  : Behavioural UserFlash responder: page erase to ones, program clears bits, flash-like busy times
// Revision : 1.0 - initial release
// ============================================================================
module uflash_emu #(
   parameter int PAGES        = 4,
   parameter int READ_CYCLES  = 2,
   parameter int PROG_CYCLES  = 16,
   parameter int ERASE_CYCLES = 128
) (
   input  wire logic clk,
   input  wire logic rst_i,
   uflash_emu_if.slave bus
);
   localparam int c_erase_n = (ERASE_CYCLES < 64) ? 64 : ERASE_CYCLES;
   localparam int c_max_rp  = (READ_CYCLES > PROG_CYCLES) ? READ_CYCLES : PROG_CYCLES;
   localparam int c_max_n   = (c_max_rp > c_erase_n) ? c_max_rp : c_erase_n;
   localparam int c_cnt_w   = $clog2(c_max_n + 1);
   localparam int c_page_w  = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam int c_depth   = PAGES * 64;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_PROG  = 2'd2,
      S_ERASE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [14:0]          r_addr;
   logic [31:0]          r_data;
   logic [5:0]           r_word;
   logic [31:0]          r_data_o;
   logic                 r_err;
   // Storage holds inverted words so a zero-initialised RAM powers up erased (all ones).
   logic [31:0]          r_mem_n [0:c_depth-1];

   logic                 w_accept;
   logic                 w_done;
   logic                 w_in_range;
   logic [c_page_w+5:0]  w_idx;
   logic [c_page_w+5:0]  w_erase_idx;

   assign w_accept    = (r_state == S_IDLE) && bus.sel;
   assign w_done      = (r_state != S_IDLE) && (r_cnt == '0);
   assign w_in_range  = (32'(r_addr[14:6]) < 32'(PAGES));
   assign w_idx       = {r_addr[6 +: c_page_w], r_addr[5:0]};
   assign w_erase_idx = {r_addr[6 +: c_page_w], r_word};

   assign bus.ready  = (r_state == S_IDLE);
   assign bus.data_o = r_data_o;
   assign bus.err    = r_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.sel) begin
               if (bus.w_strb == 4'b0000)      w_state_nxt = S_READ;
               else if (bus.w_strb == 4'b1111) w_state_nxt = S_PROG;
               else                            w_state_nxt = S_ERASE;
            end
         end
         default: begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_word   <= '0;
         r_data_o <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr <= bus.addr;
            r_data <= bus.data_i;
            r_word <= '0;
            case (w_state_nxt)
               S_READ:  r_cnt <= c_cnt_w'(READ_CYCLES - 1);
               S_PROG:  r_cnt <= c_cnt_w'(PROG_CYCLES - 1);
               default: r_cnt <= c_cnt_w'(c_erase_n - 1);
            endcase
         end else if (r_state != S_IDLE) begin
            if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_w'(1);
            if (r_state == S_ERASE) r_word <= r_word + 6'd1;
            if (w_done) begin
               r_err <= !w_in_range;
               if (r_state == S_READ) r_data_o <= w_in_range ? ~r_mem_n[w_idx] : 32'hFFFF_FFFF;
            end
         end
      end
   end

   // Erase keeps sweeping after word 63 wraps; rewriting erased words is harmless.
   always_ff @(posedge clk) begin
      if (w_in_range) begin
         if ((r_state == S_PROG) && w_done) r_mem_n[w_idx] <= r_mem_n[w_idx] | ~r_data;
         if (r_state == S_ERASE)            r_mem_n[w_erase_idx] <= '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_uflash_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_uflash_emu
// Purpose  : Self-checking bench for uflash_emu (vector table, scoreboard, corner sequences)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uflash_emu;
   localparam int PAGES = 4;

   logic clk;
   logic rst_i;
   uflash_emu_if bus();

   uflash_emu #(
      .PAGES        (PAGES),
      .READ_CYCLES  (2),
      .PROG_CYCLES  (16),
      .ERASE_CYCLES (128)
   ) dut (
      .clk   (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      logic [3:0]  cmd;
      logic [14:0] a;
      logic [31:0] d;
      int          busy;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vt[14];
   logic [31:0] m[0:PAGES*64-1];
   logic [31:0] last_rd;
   int          n_cmp;
   int          n_bad;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [14:0] a);
      if (int'(a[14:6]) >= PAGES) return 32'hFFFF_FFFF;
      return m[int'(a[14:6]) * 64 + int'(a[5:0])];
   endfunction

   task automatic model_apply(input logic [3:0] cmd, input logic [14:0] a, input logic [31:0] d);
      int base;
      if (int'(a[14:6]) >= PAGES) begin
         if (cmd == 4'b0000) last_rd = 32'hFFFF_FFFF;
         return;
      end
      base = int'(a[14:6]) * 64;
      if (cmd == 4'b0000)      last_rd = m[base + int'(a[5:0])];
      else if (cmd == 4'b1111) m[base + int'(a[5:0])] = m[base + int'(a[5:0])] & d;
      else for (int i = 0; i < 64; i++) m[base + i] = 32'hFFFF_FFFF;
   endtask

   // Issue one request, optionally pulse a stray read sel at busy sample pulse_at, then score the completion.
   task automatic run_op(input logic [3:0] cmd, input logic [14:0] a, input logic [31:0] d,
                         input int exp_busy, input logic [31:0] exp_d, input logic exp_e,
                         input int pulse_at, input string name);
      int   busy;
      bit   done;
      exp_t e;
      sb_q.push_back('{exp_d, exp_e});
      @(negedge clk);
      check({name, "_idle"}, {31'd0, bus.ready}, 32'd1);
      bus.sel = 1'b1; bus.w_strb = cmd; bus.addr = a; bus.data_i = d;
      @(posedge clk); #1;
      bus.sel = 1'b0; bus.addr = 15'($urandom); bus.data_i = $urandom;
      busy = 0; done = 0;
      for (int k = 0; k < 1000 && !done; k++) begin
         if (bus.ready) done = 1;
         else begin
            busy++;
            if (k == pulse_at) begin
               bus.sel = 1'b1; bus.w_strb = 4'b0000; bus.addr = 15'h0000;
            end
            @(posedge clk); #1;
            bus.sel = 1'b0;
         end
      end
      e = sb_q.pop_front();
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: ready still 0 after %0d cycles, want high after %0d", name, busy, exp_busy);
      end else begin
         check({name, "_busy"}, busy, exp_busy);
         check({name, "_data"}, bus.data_o, e.data);
         check({name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
         if (pulse_at >= 0) begin
            @(posedge clk); #1;
            check({name, "_noqueue"}, {31'd0, bus.ready}, 32'd1);
         end
      end
      model_apply(cmd, a, d);
   endtask

   task automatic op(input logic [3:0] cmd, input logic [14:0] a, input logic [31:0] d,
                     input int pulse_at, input string name);
      int n;
      n = (cmd == 4'b0000) ? 2 : (cmd == 4'b1111) ? 16 : 128;
      run_op(cmd, a, d, n, (cmd == 4'b0000) ? model_read(a) : last_rd,
             int'(a[14:6]) >= PAGES, pulse_at, name);
   endtask

   logic [14:0] b2b_a[3];

   initial begin
      n_cmp = 0; n_bad = 0; last_rd = 32'h0;
      for (int i = 0; i < PAGES * 64; i++) m[i] = 32'hFFFF_FFFF;

      vt[0]  = '{4'b0001, 15'h0000, 32'h0000_0000, 128, 32'h0000_0000, 1'b0};
      vt[1]  = '{4'b1111, 15'h0000, 32'hc001_cafe,  16, 32'h0000_0000, 1'b0};
      vt[2]  = '{4'b0000, 15'h0000, 32'h0000_0000,   2, 32'hc001_cafe, 1'b0};
      vt[3]  = '{4'b1111, 15'h0000, 32'h0ff0_ffff,  16, 32'hc001_cafe, 1'b0};
      vt[4]  = '{4'b0000, 15'h0000, 32'h0000_0000,   2, 32'h0000_cafe, 1'b0};
      vt[5]  = '{4'b0110, 15'h0012, 32'h0000_0000, 128, 32'h0000_cafe, 1'b0};
      vt[6]  = '{4'b0000, 15'h0000, 32'h0000_0000,   2, 32'hFFFF_FFFF, 1'b0};
      vt[7]  = '{4'b0000, 15'h0143, 32'h0000_0000,   2, 32'hFFFF_FFFF, 1'b1};
      vt[8]  = '{4'b1111, 15'h0087, 32'h1234_5678,  16, 32'hFFFF_FFFF, 1'b0};
      vt[9]  = '{4'b1111, 15'h0107, 32'h0000_0000,  16, 32'hFFFF_FFFF, 1'b1};
      vt[10] = '{4'b0000, 15'h0087, 32'h0000_0000,   2, 32'h1234_5678, 1'b0};
      vt[11] = '{4'b1000, 15'h0247, 32'h0000_0000, 128, 32'h1234_5678, 1'b1};
      vt[12] = '{4'b0000, 15'h0087, 32'h0000_0000,   2, 32'h1234_5678, 1'b0};
      vt[13] = '{4'b0000, 15'h0007, 32'h0000_0000,   2, 32'hFFFF_FFFF, 1'b0};

      rst_i = 1'b0;
      bus.sel = 1'b0; bus.w_strb = 4'b0000; bus.addr = 15'h0; bus.data_i = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, bus.ready}, 32'd1);
      check("rst_data", bus.data_o, 32'h0);
      check("rst_err", {31'd0, bus.err}, 32'd0);
      rst_i = 1'b1;

      for (int i = 0; i < 14; i++)
         run_op(vt[i].cmd, vt[i].a, vt[i].d, vt[i].busy, vt[i].exp_d, vt[i].exp_e, -1,
                $sformatf("vec%0d", i));

      // Stray sel during PROG busy, mid-window and on the completion edge itself
      op(4'b1111, 15'h00C1, 32'hA5A5_A5A5, 5, "pulse_mid");
      op(4'b0000, 15'h00C1, 32'h0, -1, "pulse_mid_rd");
      op(4'b1111, 15'h00C2, 32'h0000_0000, 15, "pulse_end");
      op(4'b0000, 15'h00C2, 32'h0, -1, "pulse_end_rd");

      // Back-to-back reads with sel held high: one accept every READ_CYCLES+1 edges
      b2b_a[0] = 15'h00C1; b2b_a[1] = 15'h0087; b2b_a[2] = 15'h00C1;
      @(negedge clk);
      bus.sel = 1'b1; bus.w_strb = 4'b0000; bus.addr = b2b_a[0];
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b%0d_busy0", i), {31'd0, bus.ready}, 32'd0);
         @(posedge clk); #1;
         check($sformatf("b2b%0d_busy1", i), {31'd0, bus.ready}, 32'd0);
         @(posedge clk); #1;
         check($sformatf("b2b%0d_done", i), {31'd0, bus.ready}, 32'd1);
         check($sformatf("b2b%0d_data", i), bus.data_o, model_read(b2b_a[i]));
         if (i < 2) bus.addr = b2b_a[i + 1];
         else bus.sel = 1'b0;
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      last_rd = model_read(b2b_a[2]);

      // Reset during erase of page 1 after words 0..9 have been swept
      for (int w = 0; w < 64; w++)
         op(4'b1111, {9'd1, 6'(w)}, 32'h0, -1, $sformatf("fill%0d", w));
      @(negedge clk);
      bus.sel = 1'b1; bus.w_strb = 4'b0001; bus.addr = {9'd1, 6'd0};
      @(posedge clk); #1;
      bus.sel = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_i = 1'b0;
      #1;
      check("abort_ready", {31'd0, bus.ready}, 32'd1);
      check("abort_data", bus.data_o, 32'h0);
      check("abort_err", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
      rst_i = 1'b1;
      for (int i = 0; i < 10; i++) m[64 + i] = 32'hFFFF_FFFF;
      last_rd = 32'h0;
      op(4'b0000, {9'd1, 6'd0},  32'h0, -1, "abort_w0");
      op(4'b0000, {9'd1, 6'd9},  32'h0, -1, "abort_w9");
      op(4'b0000, {9'd1, 6'd10}, 32'h0, -1, "abort_w10");
      op(4'b0000, {9'd1, 6'd63}, 32'h0, -1, "abort_w63");
      op(4'b0000, 15'h0087,      32'h0, -1, "nonvol_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
